// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer.
// Holds the prefix FSM state encoding and the packed key event.
package ps2_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_EXT       = 2'd1,
      S_BREAK     = 2'd2,
      S_EXT_BREAK = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT  = 8'hE0;
   localparam logic [7:0] PS2_BRK  = 8'hF0;
   localparam logic [7:0] PS2_ERR0 = 8'h00;
   localparam logic [7:0] PS2_ERR1 = 8'hFF;

   typedef struct packed {
      logic [7:0] code;
      logic       extended;
      logic       brk;
   } ps2_event_t;

   // Prefix state carries the extended/break flags of the event it closes.
   function automatic ps2_event_t make_event(input logic [7:0] code, input ps2_state_t st);
      ps2_event_t ev;
      ev.code     = code;
      ev.extended = (st == S_EXT)   || (st == S_EXT_BREAK);
      ev.brk      = (st == S_BREAK) || (st == S_EXT_BREAK);
      return ev;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; write lands at the push edge, head visible next cycle.
// Full push is dropped and flags overflow unless a pop frees the slot in the same cycle.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_clear,
   input  logic                   i_push,
   input  ps2_event_t             i_push_dat,
   input  logic                   i_pop,
   output logic                   o_vld,
   output ps2_event_t             o_dat,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_overflow
);

   localparam int AW = $clog2(DEPTH);

   ps2_event_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = i_pop && !w_empty;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign w_push  = i_push && (!w_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (i_push && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_vld      = !w_empty;
   assign o_dat      = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Folds E0/F0 prefixes into one event per key code; push at the code's first sampled cycle.
// Events queue in a FIFO drained by Event_valid/Event_ready; pending prefixes time out.
module ps2_scan_sequencer
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                        Clock_50,
   input  logic                        Reset,
   input  logic                        Enable,
   input  logic                        Clear,
   input  logic [7:0]                  PS2_code,
   input  logic                        PS2_code_ready,
   output logic                        Event_valid,
   input  logic                        Event_ready,
   output logic [7:0]                  Event_code,
   output logic                        Event_extended,
   output logic                        Event_break,
   output logic [$clog2(FIFO_DEPTH):0] Event_count,
   output logic                        Overflow
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   ps2_state_t r_state;
   ps2_state_t w_state_nxt;
   ps2_state_t w_cur;
   logic       r_ready_q;
   logic [TW-1:0] r_timer;
   logic       w_strobe;
   logic       w_timeout;
   logic       w_push;
   ps2_event_t w_event;
   ps2_event_t w_head;

   // Reset to 1 so a receiver flag already high at reset release is not a new code.
   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         r_ready_q <= 1'b1;
      end else begin
         r_ready_q <= PS2_code_ready;
      end
   end

   assign w_strobe  = Enable && PS2_code_ready && !r_ready_q;
   assign w_timeout = (r_state != S_IDLE) && (r_timer == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_event     = '0;
      // An expiring prefix is dropped; a coincident code is decoded as unprefixed.
      w_cur       = w_timeout ? S_IDLE : r_state;
      if (!Enable) begin
         w_state_nxt = S_IDLE;
      end else if (w_strobe) begin
         case (PS2_code)
            PS2_EXT: begin
               case (w_cur)
                  S_IDLE:  w_state_nxt = S_EXT;
                  S_BREAK: w_state_nxt = S_EXT_BREAK;
                  default: w_state_nxt = w_cur;
               endcase
            end
            PS2_BRK: begin
               case (w_cur)
                  S_IDLE:  w_state_nxt = S_BREAK;
                  S_EXT:   w_state_nxt = S_EXT_BREAK;
                  default: w_state_nxt = w_cur;
               endcase
            end
            PS2_ERR0, PS2_ERR1: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_push      = 1'b1;
               w_event     = make_event(PS2_code, w_cur);
               w_state_nxt = S_IDLE;
            end
         endcase
      end else if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge Clock_50) begin
      if (Reset || Clear) begin
         r_state <= S_IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_strobe || (w_state_nxt == S_IDLE)) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (Clock_50),
      .i_reset    (Reset),
      .i_clear    (Clear),
      .i_push     (w_push),
      .i_push_dat (w_event),
      .i_pop      (Event_ready),
      .o_vld      (Event_valid),
      .o_dat      (w_head),
      .o_count    (Event_count),
      .o_overflow (Overflow)
   );

   assign Event_code     = w_head.code;
   assign Event_extended = w_head.extended;
   assign Event_break    = w_head.brk;

endmodule
